// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: scans operands MSB digit first, DIGIT bits per clock,
// stopping at the first differing digit. Signed compare uses an offset-binary MSB flip.
module seq_mag_comp #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [WIDTH-1:0] flip;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic             last_digit;

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  assign flip       = signed_mode ? MSB_MASK : '0;
  assign dig_a      = a_q[WIDTH-1 -: DIGIT];
  assign dig_b      = b_q[WIDTH-1 -: DIGIT];
  assign last_digit = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a ^ flip;
          b_d     = b ^ flip;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dig_a != dig_b) begin
          gt_d    = (dig_a > dig_b);
          lt_d    = (dig_a < dig_b);
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (last_digit) begin
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Scoreboard bench for seq_mag_comp (WIDTH=8, DIGIT=2): expected result and done cycle are
// queued at each accepted start and checked when done pulses.
module tb_seq_mag_comp;

  logic       clk = 1'b0;
  logic       rst, start, signed_mode;
  logic [7:0] a, b;
  logic       busy, done, gt, eq, lt;

  typedef struct {
    logic [2:0] res;
    int         done_cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  logic [2:0] last_res = 3'b000;

  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  seq_mag_comp #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: 1-based index of the first differing 2-bit digit (MSB first).
  function automatic int first_diff(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    d = x ^ y;
    for (int i = 0; i < 4; i++)
      if (d[7-2*i -: 2] != 2'b00) return i + 1;
    return 4;
  endfunction

  function automatic logic [2:0] ref_res(input logic [7:0] x, input logic [7:0] y, input logic sm);
    if (sm) begin
      if ($signed(x) > $signed(y)) return R_GT;
      if ($signed(x) < $signed(y)) return R_LT;
    end else begin
      if (x > y) return R_GT;
      if (x < y) return R_LT;
    end
    return R_EQ;
  endfunction

  // Called at a negedge; the following posedge samples start (cycle 0 = current cyc).
  task automatic start_cmp(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                           input logic [2:0] res, input int k);
    exp_t e;
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    e.res = res;
    e.done_cyc = cyc + k + 1;
    sb_q.push_back(e);
    $display("start a=%02h b=%02h signed=%0d exp_res=%03b k=%0d", av, bv, sm, res, k);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("timeout", 1, 0);
    @(negedge clk);
  endtask

  // Monitor: compare every done pulse with the scoreboard; results must hold while busy.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", {gt, eq, lt}, e.res);
        check("done_cycle", cyc, e.done_cyc);
        check("busy_in_done", busy, 0);
        last_res = e.res;
        $display("done gt=%0d eq=%0d lt=%0d at cycle %0d", gt, eq, lt, cyc);
      end
    end else if (busy) begin
      check("hold_while_busy", {gt, eq, lt}, last_res);
    end
  end

  initial begin
    int t0;
    logic [7:0] ra, rb;
    logic       rs;
    rst = 1'b1; start = 1'b1; signed_mode = 1'b0; a = 8'hA5; b = 8'h5A;

    // Reset held two cycles with start high: nothing may start.
    repeat (2) begin
      @(negedge clk);
      check("reset_outs", {busy, done, gt, eq, lt}, 5'b0);
    end
    rst = 1'b0; start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_reset_idle", {busy, done, gt, eq, lt}, 5'b0);
    end

    // Unsigned early exit on digit 1.
    start_cmp(8'hA5, 8'h5A, 1'b0, R_GT, 1);
    wait_idle();

    // Full scan, equal; a start pulsed at cycle 2 must be ignored.
    t0 = cyc;
    start_cmp(8'h3C, 8'h3C, 1'b0, R_EQ, 4);
    check("busy_c1", busy, 1);
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    check("busy_c2", busy, 1);
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("busy_c3_4", busy, 1);
    end
    @(negedge clk);
    check("done_c5_cycle", cyc - t0, 5);
    check("busy_c5", busy, 0);
    repeat (4) @(negedge clk);
    check("no_second_done", sb_q.size(), 0);

    // Signed vs unsigned on the same operands.
    start_cmp(8'h80, 8'h7F, 1'b1, R_LT, 1);
    wait_idle();
    start_cmp(8'h80, 8'h7F, 1'b0, R_GT, 1);
    wait_idle();

    // Last-digit difference, then back-to-back start at cycle 6.
    start_cmp(8'h12, 8'h13, 1'b0, R_LT, 4);
    repeat (5) @(negedge clk);
    start_cmp(8'hFF, 8'h00, 1'b0, R_GT, 1);
    wait_idle();

    // Reset mid-operation: no done pulse, outputs return to zero.
    a = 8'h3C; b = 8'h3C; signed_mode = 1'b0; start = 1'b1;
    $display("start a=3c b=3c signed=0 (aborted by reset)");
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_res = 3'b000;
    check("midop_reset_outs", {busy, done, gt, eq, lt}, 5'b0);
    repeat (5) begin
      @(negedge clk);
      check("midop_no_done", {busy, done, gt, eq, lt}, 5'b0);
    end
    start_cmp(8'h3C, 8'h3D, 1'b0, R_LT, 4);
    wait_idle();

    // Random operands and modes, issued as soon as the comparator returns to IDLE.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? ra : 8'($urandom);
      if (i % 5 == 1) rb = ra ^ 8'h01;
      rs = 1'($urandom);
      start_cmp(ra, rb, rs, ref_res(ra, rb, rs), first_diff(ra, rb));
      wait_idle();
    end

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
